// File: rtl/motion_correct_scheduler_if.sv
// Bus bundle between the motion-correct scheduler, its point source/sink and the corrector.
// master = scheduler side, slave = environment (ingest, corrector, cloud writer).
interface motion_correct_scheduler_if #(
    parameter int unsigned WP     = 32,
    parameter int unsigned NPTS_W = 16
) ();
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WP-1:0]     cfg_t_ref;
    logic [WP-1:0]     cfg_vx;
    logic [WP-1:0]     cfg_vy;
    logic [WP-1:0]     cfg_vz;
    logic [NPTS_W-1:0] cfg_npts;

    logic              in_valid;
    logic              in_ready;
    logic [WP-1:0]     in_px;
    logic [WP-1:0]     in_py;
    logic [WP-1:0]     in_pz;
    logic [WP-1:0]     in_t;

    logic [WP-1:0]     corr_px;
    logic [WP-1:0]     corr_py;
    logic [WP-1:0]     corr_pz;
    logic [WP-1:0]     corr_dt;
    logic [WP-1:0]     corr_vx;
    logic [WP-1:0]     corr_vy;
    logic [WP-1:0]     corr_vz;
    logic [WP-1:0]     corr_cx;
    logic [WP-1:0]     corr_cy;
    logic [WP-1:0]     corr_cz;

    logic              out_valid;
    logic              out_ready;
    logic [WP-1:0]     out_cx;
    logic [WP-1:0]     out_cy;
    logic [WP-1:0]     out_cz;
    logic              out_last;

    modport master (
        input  cfg_valid, cfg_t_ref, cfg_vx, cfg_vy, cfg_vz, cfg_npts,
        input  in_valid, in_px, in_py, in_pz, in_t,
        input  corr_cx, corr_cy, corr_cz,
        input  out_ready,
        output cfg_ready, in_ready,
        output corr_px, corr_py, corr_pz, corr_dt, corr_vx, corr_vy, corr_vz,
        output out_valid, out_cx, out_cy, out_cz, out_last
    );

    modport slave (
        output cfg_valid, cfg_t_ref, cfg_vx, cfg_vy, cfg_vz, cfg_npts,
        output in_valid, in_px, in_py, in_pz, in_t,
        output corr_cx, corr_cy, corr_cz,
        output out_ready,
        input  cfg_ready, in_ready,
        input  corr_px, corr_py, corr_pz, corr_dt, corr_vx, corr_vy, corr_vz,
        input  out_valid, out_cx, out_cy, out_cz, out_last
    );
endinterface

// File: rtl/motion_correct_scheduler.sv
// Frame scheduler for the shared motion-corrector: latches frame config, computes saturated dt,
// drives the corrector from an s1 register stage and captures its result into a valid/ready stage.
module motion_correct_scheduler #(
    parameter int unsigned WP     = 32,
    parameter int unsigned NPTS_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       abort,
    motion_correct_scheduler_if.master bus,
    output logic                       done,
    output logic                       busy,
    output logic                       dt_sat
);
    typedef enum logic {StIdle, StStream} state_e;

    state_e            state_q, state_d;
    logic              done_q, done_d;
    logic              dt_sat_q;
    logic [NPTS_W-1:0] npts_q, in_cnt_q, out_cnt_q;
    logic [WP-1:0]     t_ref_q;
    logic              s1_valid_q, s1_last_q;
    logic [WP-1:0]     corr_px_q, corr_py_q, corr_pz_q, corr_dt_q;
    logic [WP-1:0]     corr_vx_q, corr_vy_q, corr_vz_q;
    logic              out_valid_q, out_last_q;
    logic [WP-1:0]     out_cx_q, out_cy_q, out_cz_q;

    logic              cfg_fire, in_fire, out_fire, s2_adv, s1_adv, frame_end;
    logic signed [WP:0] dt_wide;
    logic              dt_clamp;
    logic [WP-1:0]     dt_val;

    assign bus.cfg_ready = (state_q == StIdle) && !abort;
    assign s2_adv        = !out_valid_q || bus.out_ready;
    assign s1_adv        = s1_valid_q && s2_adv;
    assign bus.in_ready  = (state_q == StStream) && (in_cnt_q < npts_q) &&
                           (!s1_valid_q || s2_adv) && !abort;
    assign cfg_fire      = bus.cfg_valid && bus.cfg_ready;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign out_fire      = out_valid_q && bus.out_ready && !abort;
    assign frame_end     = (state_q == StStream) && out_fire && !s1_valid_q &&
                           (in_cnt_q == npts_q) && ((out_cnt_q + NPTS_W'(1)) == npts_q);

    // One extra bit makes the difference exact; overflow shows as disagreeing top two bits.
    assign dt_wide  = $signed({bus.in_t[WP-1], bus.in_t}) - $signed({t_ref_q[WP-1], t_ref_q});
    assign dt_clamp = dt_wide[WP] ^ dt_wide[WP-1];

    always_comb begin
        dt_val = dt_wide[WP-1:0];
        if (dt_clamp) begin
            dt_val = dt_wide[WP] ? {1'b1, {(WP-1){1'b0}}} : {1'b0, {(WP-1){1'b1}}};
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cfg_fire) begin
                    if (bus.cfg_npts == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StStream;
                    end
                end
            end
            StStream: begin
                if (frame_end) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            done_q      <= 1'b0;
            dt_sat_q    <= 1'b0;
            npts_q      <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            t_ref_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            corr_px_q   <= '0;
            corr_py_q   <= '0;
            corr_pz_q   <= '0;
            corr_dt_q   <= '0;
            corr_vx_q   <= '0;
            corr_vy_q   <= '0;
            corr_vz_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_cx_q    <= '0;
            out_cy_q    <= '0;
            out_cz_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (cfg_fire) begin
                npts_q    <= bus.cfg_npts;
                t_ref_q   <= bus.cfg_t_ref;
                corr_vx_q <= bus.cfg_vx;
                corr_vy_q <= bus.cfg_vy;
                corr_vz_q <= bus.cfg_vz;
                in_cnt_q  <= '0;
                out_cnt_q <= '0;
                dt_sat_q  <= 1'b0;
            end
            if (abort) begin
                s1_valid_q  <= 1'b0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                if (in_fire) begin
                    corr_px_q  <= bus.in_px;
                    corr_py_q  <= bus.in_py;
                    corr_pz_q  <= bus.in_pz;
                    corr_dt_q  <= dt_val;
                    s1_valid_q <= 1'b1;
                    s1_last_q  <= (in_cnt_q + NPTS_W'(1)) == npts_q;
                    in_cnt_q   <= in_cnt_q + NPTS_W'(1);
                    if (dt_clamp) begin
                        dt_sat_q <= 1'b1;
                    end
                end else if (s1_adv) begin
                    s1_valid_q <= 1'b0;
                end
                // Corrector is combinational from the s1 registers; capture its result here.
                if (s1_adv) begin
                    out_cx_q    <= bus.corr_cx;
                    out_cy_q    <= bus.corr_cy;
                    out_cz_q    <= bus.corr_cz;
                    out_valid_q <= 1'b1;
                    out_last_q  <= s1_last_q;
                end else if (out_fire) begin
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
                if (out_fire) begin
                    out_cnt_q <= out_cnt_q + NPTS_W'(1);
                end
            end
        end
    end

    assign bus.corr_px   = corr_px_q;
    assign bus.corr_py   = corr_py_q;
    assign bus.corr_pz   = corr_pz_q;
    assign bus.corr_dt   = corr_dt_q;
    assign bus.corr_vx   = corr_vx_q;
    assign bus.corr_vy   = corr_vy_q;
    assign bus.corr_vz   = corr_vz_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_cx    = out_cx_q;
    assign bus.out_cy    = out_cy_q;
    assign bus.out_cz    = out_cz_q;
    assign done          = done_q;
    assign busy          = (state_q != StIdle);
    assign dt_sat        = dt_sat_q;
endmodule

// File: tb/tb_motion_correct_scheduler.sv
// Directed bench for motion_correct_scheduler; the corrector (c = p + (v*dt)>>>16) lives here
// as a combinational block on the interface.
module tb_motion_correct_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort = 1'b0;
    logic done, busy, dt_sat;
    int   errors = 0;
    int   checks = 0;

    motion_correct_scheduler_if #(.WP(32), .NPTS_W(16)) bus ();

    motion_correct_scheduler #(.WP(32), .NPTS_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .abort  (abort),
        .bus    (bus),
        .done   (done),
        .busy   (busy),
        .dt_sat (dt_sat)
    );

    always #5 clk = ~clk;

    logic signed [63:0] prod_x, prod_y, prod_z;
    always_comb begin
        prod_x = $signed({{32{bus.corr_vx[31]}}, bus.corr_vx}) *
                 $signed({{32{bus.corr_dt[31]}}, bus.corr_dt});
        prod_y = $signed({{32{bus.corr_vy[31]}}, bus.corr_vy}) *
                 $signed({{32{bus.corr_dt[31]}}, bus.corr_dt});
        prod_z = $signed({{32{bus.corr_vz[31]}}, bus.corr_vz}) *
                 $signed({{32{bus.corr_dt[31]}}, bus.corr_dt});
        bus.corr_cx = bus.corr_px + prod_x[47:16];
        bus.corr_cy = bus.corr_py + prod_y[47:16];
        bus.corr_cz = bus.corr_pz + prod_z[47:16];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input logic [31:0] t_ref, input logic [31:0] vx,
                            input logic [15:0] npts);
        bus.cfg_t_ref = t_ref;
        bus.cfg_vx    = vx;
        bus.cfg_vy    = '0;
        bus.cfg_vz    = '0;
        bus.cfg_npts  = npts;
        bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        checks++; if (bus.cfg_ready !== 1'b1) begin errors++;
            $display("FAIL reset_cfg_ready got=%b exp=1", bus.cfg_ready); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (bus.out_valid !== 1'b0 || done !== 1'b0 || dt_sat !== 1'b0) begin errors++;
            $display("FAIL reset_flags got=%b%b%b exp=000", bus.out_valid, done, dt_sat); end
        checks++; if (bus.corr_dt !== 32'h0 || bus.corr_vx !== 32'h0) begin errors++;
            $display("FAIL reset_corr got=%h/%h exp=0/0", bus.corr_dt, bus.corr_vx); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++;
            $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    endtask

    task automatic test_single_point();
        send_cfg(32'h0001_0000, 32'h0001_0000, 16'd1);
        checks++; if (busy !== 1'b1) begin errors++;
            $display("FAIL t1_busy got=%b exp=1", busy); end
        bus.in_px = 32'h0005_0000; bus.in_py = '0; bus.in_pz = '0;
        bus.in_t = 32'h0003_0000; bus.in_valid = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL t1_in_ready got=%b exp=1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.corr_dt !== 32'h0002_0000) begin errors++;
            $display("FAIL t1_corr_dt got=%h exp=00020000", bus.corr_dt); end
        checks++; if (bus.corr_vx !== 32'h0001_0000) begin errors++;
            $display("FAIL t1_corr_vx got=%h exp=00010000", bus.corr_vx); end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_cx !== 32'h0007_0000) begin errors++;
            $display("FAIL t1_out got=%b/%h exp=1/00070000", bus.out_valid, bus.out_cx); end
        checks++; if (bus.out_last !== 1'b1 || bus.out_cy !== 32'h0) begin errors++;
            $display("FAIL t1_last got=%b/%h exp=1/0", bus.out_last, bus.out_cy); end
        tick();
        checks++; if (done !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++;
            $display("FAIL t1_done got=%b%b%b exp=100", done, busy, bus.out_valid); end
        tick();
        checks++; if (done !== 1'b0) begin errors++;
            $display("FAIL t1_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_back_to_back();
        int  acc = 0;
        logic rdy, exp_v;
        send_cfg(32'h0, 32'h0002_0000, 16'd4);
        bus.in_t = 32'h0001_0000; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.in_px = 32'(acc << 16);
            #1;
            rdy = bus.in_ready;
            checks++; if (rdy !== (c < 4)) begin errors++;
                $display("FAIL t2_in_ready c=%0d got=%b exp=%b", c, rdy, c < 4); end
            tick();
            if (rdy) acc++;
            exp_v = (c >= 1 && c <= 4);
            checks++; if (bus.out_valid !== exp_v) begin errors++;
                $display("FAIL t2_out_valid c=%0d got=%b exp=%b", c, bus.out_valid, exp_v); end
            if (exp_v) begin
                checks++; if (bus.out_cx !== 32'((c + 1) << 16) || bus.out_last !== (c == 4))
                begin errors++;
                    $display("FAIL t2_out c=%0d got=%h/%b exp=%h/%b", c, bus.out_cx,
                             bus.out_last, 32'((c + 1) << 16), c == 4); end
            end
        end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++;
            $display("FAIL t2_done got=%b%b exp=10", done, busy); end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int  acc = 0;
        logic rdy;
        send_cfg(32'h0, 32'h0, 16'd3);
        bus.in_t = 32'h0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.in_px = 32'((acc + 10) << 16);
            #1;
            rdy = bus.in_ready;
            checks++; if (rdy !== (c < 2)) begin errors++;
                $display("FAIL t3_in_ready c=%0d got=%b exp=%b", c, rdy, c < 2); end
            tick();
            if (rdy) acc++;
        end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_cx !== 32'h000A_0000) begin errors++;
            $display("FAIL t3_hold got=%b/%h exp=1/000a0000", bus.out_valid, bus.out_cx); end
        bus.cfg_valid = 1'b1;
        #1;
        checks++; if (bus.cfg_ready !== 1'b0) begin errors++;
            $display("FAIL t3_cfg_ready got=%b exp=0", bus.cfg_ready); end
        tick();
        bus.cfg_valid = 1'b0;
        checks++; if (busy !== 1'b1 || bus.out_cx !== 32'h000A_0000) begin errors++;
            $display("FAIL t3_cfg_ignored got=%b/%h exp=1/000a0000", busy, bus.out_cx); end
        bus.out_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            bus.in_px = 32'((acc + 10) << 16);
            #1;
            rdy = bus.in_ready;
            checks++; if (rdy !== (r == 0)) begin errors++;
                $display("FAIL t3_rel_ready r=%0d got=%b exp=%b", r, rdy, r == 0); end
            tick();
            if (rdy) acc++;
            if (r < 2) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_cx !== 32'((r + 11) << 16) ||
                              bus.out_last !== (r == 1)) begin errors++;
                    $display("FAIL t3_out r=%0d got=%b/%h/%b exp=1/%h/%b", r, bus.out_valid,
                             bus.out_cx, bus.out_last, 32'((r + 11) << 16), r == 1); end
            end else begin
                checks++; if (done !== 1'b1 || bus.out_valid !== 1'b0) begin errors++;
                    $display("FAIL t3_done got=%b/%b exp=1/0", done, bus.out_valid); end
            end
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_dt_saturation();
        send_cfg(32'h8000_0000, 32'h0, 16'd2);
        bus.out_ready = 1'b1;
        bus.in_px = 32'h0003_0000; bus.in_t = 32'hFFFF_FFFF; bus.in_valid = 1'b1;
        tick();
        checks++; if (bus.corr_dt !== 32'h7FFF_FFFF || dt_sat !== 1'b0) begin errors++;
            $display("FAIL t4_edge got=%h/%b exp=7fffffff/0", bus.corr_dt, dt_sat); end
        bus.in_t = 32'h7FFF_0000;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.corr_dt !== 32'h7FFF_FFFF || dt_sat !== 1'b1) begin errors++;
            $display("FAIL t4_sat got=%h/%b exp=7fffffff/1", bus.corr_dt, dt_sat); end
        tick();
        tick();
        checks++; if (done !== 1'b1 || dt_sat !== 1'b1) begin errors++;
            $display("FAIL t4_sticky got=%b/%b exp=1/1", done, dt_sat); end
        tick();
    endtask

    task automatic test_zero_points();
        send_cfg(32'h0, 32'h0, 16'd0);
        checks++; if (dt_sat !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin errors++;
            $display("FAIL t5_cfg got=%b%b%b exp=001", dt_sat, busy, done); end
        bus.in_valid = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++;
            $display("FAIL t5_in_ready got=%b exp=0", bus.in_ready); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL t5_after got=%b%b exp=00", done, busy); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_abort();
        send_cfg(32'h0, 32'h0, 16'd5);
        bus.out_ready = 1'b0; bus.in_t = 32'h0; bus.in_px = 32'h0004_0000; bus.in_valid = 1'b1;
        tick();
        tick();
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin errors++;
            $display("FAIL t6_full got=%b/%b exp=0/1", bus.in_ready, bus.out_valid); end
        abort = 1'b1;
        tick();
        abort = 1'b0; bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL t6_flush got=%b%b%b exp=000", bus.out_valid, busy, done); end
        checks++; if (bus.cfg_ready !== 1'b1) begin errors++;
            $display("FAIL t6_cfg_ready got=%b exp=1", bus.cfg_ready); end
        tick();
        checks++; if (done !== 1'b0 || bus.out_valid !== 1'b0) begin errors++;
            $display("FAIL t6_no_done got=%b/%b exp=0/0", done, bus.out_valid); end
        send_cfg(32'h0, 32'h0, 16'd1);
        bus.in_px = 32'h0009_0000; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_cx !== 32'h0009_0000 || bus.out_last !== 1'b1) begin errors++;
            $display("FAIL t6_new_frame got=%h/%b exp=00090000/1", bus.out_cx, bus.out_last); end
        tick();
        checks++; if (done !== 1'b1) begin errors++;
            $display("FAIL t6_new_done got=%b exp=1", done); end
    endtask

    initial begin
        bus.cfg_valid = 1'b0; bus.cfg_t_ref = '0; bus.cfg_vx = '0; bus.cfg_vy = '0;
        bus.cfg_vz = '0; bus.cfg_npts = '0;
        bus.in_valid = 1'b0; bus.in_px = '0; bus.in_py = '0; bus.in_pz = '0; bus.in_t = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        test_reset();
        test_single_point();
        test_back_to_back();
        test_backpressure();
        test_dt_saturation();
        test_zero_points();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
